// File: rtl/tx_sr_pkg.sv
// -----------------------------------------------------------------------------
// tx_sr_pkg
//
// Shared definitions for the transmit shift controller (tx_sr) and its
// parallel-to-serial shift register.
//
//   tx_state_t      : controller states (IDLE, DATA, ACK, DONE)
//   BYTE_BITS       : bits per byte on the serial line
//   ACK_BIT         : SDA level the receiver drives for an acknowledge
//   NACK_BIT        : SDA level seen for a not-acknowledge (line released)
//   byte_cnt_width(): width of the byte counter, never narrower than 1 bit
// -----------------------------------------------------------------------------
package tx_sr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } tx_state_t;

  localparam int   BYTE_BITS = 8;
  localparam logic ACK_BIT   = 1'b0;
  localparam logic NACK_BIT  = 1'b1;

  // $clog2(1) is 0, so a single-byte build still gets a 1-bit counter.
  function automatic int byte_cnt_width(input int num_bytes);
    return (num_bytes > 1) ? $clog2(num_bytes) : 1;
  endfunction

endpackage

// File: rtl/tx_sr_flex_pts_sr.sv
// -----------------------------------------------------------------------------
// flex_pts_sr
//
// Parameterised parallel-to-serial shift register, the transmit-side twin of
// flex_stp_sr. Load has priority over shift. Shifting moves toward the MSB
// with zero fill, so serial_out always presents the most significant bit.
//
// Ports:
//   clk          in   system clock
//   n_rst        in   asynchronous active-low reset (register cleared to 0)
//   load_enable  in   capture parallel_in
//   shift_enable in   shift left by one, zero fill
//   parallel_in  in   NUM_BITS-wide word to load
//   serial_out   out  current MSB of the register
// -----------------------------------------------------------------------------
module flex_pts_sr #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] r_data;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data <= '0;
    end else if (load_enable) begin
      r_data <= parallel_in;
    end else if (shift_enable) begin
      r_data <= {r_data[NUM_BITS-2:0], 1'b0};
    end
  end

  assign serial_out = r_data[NUM_BITS-1];

endmodule

// File: rtl/tx_sr.sv
// -----------------------------------------------------------------------------
// tx_sr
//
// Transmit-side shift controller for the serial data line. Loads a
// NUM_BYTES*8-bit word and drives it MSB-first on SDA, one bit per SCL
// falling-edge pulse. After each byte SDA is released for an acknowledge
// slot; the receiver's level is captured on the SCL rising edge.
//
// Optional feature (compile-time macro TX_SR_NACK_ABORT_EN):
//   defined   : a NACK ends the transfer at the falling edge closing that
//               acknowledge slot; remaining bytes are not sent.
//   undefined : a NACK only sets the sticky nack flag; all bytes are sent.
//
// Ports:
//   clk                in   system clock
//   n_rst              in   asynchronous active-low reset
//   load               in   one-cycle start request, honoured only in IDLE
//   tx_data            in   payload, bit [NUM_BYTES*8-1] sent first
//   tx_enable          in   0 = ignore edge pulses, hold everything
//   falling_edge_found in   one-cycle SCL falling-edge pulse
//   rising_edge_found  in   one-cycle SCL rising-edge pulse
//   sda_in             in   synchronised SDA, sampled in the ACK slot
//   sda_out            out  SDA drive value, 1 = released
//   busy               out  high in DATA and ACK
//   done               out  one-cycle pulse at transfer end
//   nack               out  sticky NACK flag for the current/last transfer
//   dbg_state          out  current controller state (tx_state_t encoding)
//
// Handshake: load is a request without backpressure. It is accepted only in
// the cycle it is seen in IDLE; busy then rises the next cycle, and done
// pulses once (with busy already low) when the transfer completes. A load
// seen while not IDLE is dropped, never queued.
// -----------------------------------------------------------------------------
module tx_sr
  import tx_sr_pkg::*;
#(
  parameter int NUM_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   load,
  input  logic [NUM_BYTES*8-1:0] tx_data,
  input  logic                   tx_enable,
  input  logic                   falling_edge_found,
  input  logic                   rising_edge_found,
  input  logic                   sda_in,
  output logic                   sda_out,
  output logic                   busy,
  output logic                   done,
  output logic                   nack,
  output logic [1:0]             dbg_state
);

  localparam int             BCW       = byte_cnt_width(NUM_BYTES);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(BYTE_BITS - 1);

  tx_state_t      r_state;
  tx_state_t      w_next_state;
  logic [2:0]     r_bit_cnt;
  logic [BCW-1:0] r_byte_cnt;
  logic           r_nack;

  logic w_fall;
  logic w_rise;
  logic w_abort;
  logic w_sr_load;
  logic w_sr_shift;
  logic w_sr_msb;
  logic w_bit_clr;
  logic w_bit_inc;
  logic w_byte_clr;
  logic w_byte_inc;
  logic w_nack_clr;
  logic w_ack_cap;

  // Edge pulses only count while enabled. A falling pulse wins over a
  // coincident rising pulse, which is simply dropped.
  assign w_fall = falling_edge_found & tx_enable;
  assign w_rise = rising_edge_found & tx_enable & ~falling_edge_found;

  // ---------------------------------------------------------------------------
  // Acknowledge level of the current slot. Cleared on entry to ACK so a slot
  // without any rising edge reads as an acknowledge.
  // ---------------------------------------------------------------------------
`ifdef TX_SR_NACK_ABORT_EN
  logic r_ack_bit;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ack_bit <= ACK_BIT;
    end else if (r_state == DATA && w_next_state == ACK) begin
      r_ack_bit <= ACK_BIT;
    end else if (w_ack_cap) begin
      r_ack_bit <= sda_in;
    end
  end

  assign w_abort = (r_ack_bit == NACK_BIT);
`else
  assign w_abort = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_sr_load    = 1'b0;
    w_sr_shift   = 1'b0;
    w_bit_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    w_byte_clr   = 1'b0;
    w_byte_inc   = 1'b0;
    w_nack_clr   = 1'b0;
    w_ack_cap    = 1'b0;

    case (r_state)
      IDLE: begin
        if (load) begin
          w_sr_load    = 1'b1;
          w_bit_clr    = 1'b1;
          w_byte_clr   = 1'b1;
          w_nack_clr   = 1'b1;
          w_next_state = DATA;
        end
      end

      DATA: begin
        if (w_fall) begin
          if (r_bit_cnt == LAST_BIT) begin
            // Last bit of the byte stays on the line until the ACK slot
            // starts; the register is not shifted here.
            w_bit_clr    = 1'b1;
            w_next_state = ACK;
          end else begin
            w_sr_shift = 1'b1;
            w_bit_inc  = 1'b1;
          end
        end
      end

      ACK: begin
        if (w_fall) begin
          if (w_abort || r_byte_cnt == LAST_BYTE) begin
            w_next_state = DONE;
          end else begin
            // Shift past the final bit of the byte just sent so the next
            // byte's MSB is on top when DATA resumes.
            w_sr_shift   = 1'b1;
            w_byte_inc   = 1'b1;
            w_next_state = DATA;
          end
        end else if (w_rise) begin
          w_ack_cap = 1'b1;
        end
      end

      DONE: begin
        w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and sticky NACK
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_cnt <= 3'd0;
    end else if (w_bit_clr) begin
      r_bit_cnt <= 3'd0;
    end else if (w_bit_inc) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_byte_cnt <= '0;
    end else if (w_byte_clr) begin
      r_byte_cnt <= '0;
    end else if (w_byte_inc) begin
      r_byte_cnt <= r_byte_cnt + BCW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_nack <= 1'b0;
    end else if (w_nack_clr) begin
      r_nack <= 1'b0;
    end else if (w_ack_cap && sda_in == NACK_BIT) begin
      r_nack <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload shift register
  // ---------------------------------------------------------------------------
  flex_pts_sr #(
    .NUM_BITS (NUM_BYTES * BYTE_BITS)
  ) u_pts_sr (
    .clk          (clk),
    .n_rst        (n_rst),
    .load_enable  (w_sr_load),
    .shift_enable (w_sr_shift),
    .parallel_in  (tx_data),
    .serial_out   (w_sr_msb)
  );

  // ---------------------------------------------------------------------------
  // Outputs. Everything here is decoded from flops only, so SDA never sees a
  // combinational path from the module inputs.
  // ---------------------------------------------------------------------------
  assign sda_out   = (r_state == DATA) ? w_sr_msb : 1'b1;
  assign busy      = (r_state == DATA) || (r_state == ACK);
  assign done      = (r_state == DONE);
  assign nack      = r_nack;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tx_sr.sv
// -----------------------------------------------------------------------------
// tb_tx_sr
//
// Bench for tx_sr. Two instances share clock, reset and the SCL/SDA side:
// u_tx1 (NUM_BYTES=1) and u_tx16 (NUM_BYTES=16); each has its own load and
// payload, and only one is ever loaded at a time (the idle one ignores edges).
// Expected serial slots (8 data bits then a released ACK slot per byte) are
// pushed at load time and popped as each slot is observed on SDA.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tx_sr;
  import tx_sr_pkg::*;

  localparam int W = 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic         load1, load16;
  logic [7:0]   tx1;
  logic [127:0] tx16;
  logic         tx_enable, fall, rise, sda_in;
  logic         sda1, busy1, done1, nack1;
  logic         sda16, busy16, done16, nack16;
  logic [1:0]   st1, st16;

  tx_sr #(.NUM_BYTES(1)) u_tx1 (
    .clk                (clk),
    .n_rst              (n_rst),
    .load               (load1),
    .tx_data            (tx1),
    .tx_enable          (tx_enable),
    .falling_edge_found (fall),
    .rising_edge_found  (rise),
    .sda_in             (sda_in),
    .sda_out            (sda1),
    .busy               (busy1),
    .done               (done1),
    .nack               (nack1),
    .dbg_state          (st1)
  );

  tx_sr #(.NUM_BYTES(16)) u_tx16 (
    .clk                (clk),
    .n_rst              (n_rst),
    .load               (load16),
    .tx_data            (tx16),
    .tx_enable          (tx_enable),
    .falling_edge_found (fall),
    .rising_edge_found  (rise),
    .sda_in             (sda_in),
    .sda_out            (sda16),
    .busy               (busy16),
    .done               (done16),
    .nack               (nack16),
    .dbg_state          (st16)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and checker
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_sda(input int sel);
    return (sel == 1) ? sda1 : sda16;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy1 : busy16;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 1) ? done1 : done16;
  endfunction
  function automatic logic get_nack(input int sel);
    return (sel == 1) ? nack1 : nack16;
  endfunction
  function automatic logic [1:0] get_state(input int sel);
    return (sel == 1) ? st1 : st16;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one complete transfer on instance sel (1 or 16).
  //   nack_byte  : byte index whose ACK slot sees SDA high (-1 = none)
  //   stall_slot : slot before which tx_enable drops for 20 pulsing cycles
  //   coin_slot  : slot closed by a coincident rise/fall pulse with sda_in=1
  //                and a competing load of inverted data
  //   reset_slot : slot in which reset hits after the rising pulse
  // All driving and sampling happens on the falling clock edge.
  // ---------------------------------------------------------------------------
  task automatic run_xfer(input int sel, input logic [127:0] data, input int nack_byte,
                          input int stall_slot, input int coin_slot, input int reset_slot,
                          input string tag);
    int   nb, sent, edges, slot_pos, slot_byte;
    logic saw_done, bail, dn;
    nb   = (sel == 1) ? 1 : 16;
    sent = nb;
`ifdef TX_SR_NACK_ABORT_EN
    if (nack_byte >= 0) sent = nack_byte + 1;
`endif
    exp_q.delete();

    @(negedge clk);
    if (sel == 1) begin load1 = 1'b1; tx1 = data[7:0]; end
    else begin load16 = 1'b1; tx16 = data; end
    for (int b = 0; b < sent; b++) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(data[(nb - 1 - b) * 8 + i]);
      exp_q.push_back(1'b1);
    end
    @(negedge clk);
    load1  = 1'b0;
    load16 = 1'b0;
    check({tag, "_busy_start"}, get_busy(sel), 1'b1);

    edges    = 0;
    saw_done = 1'b0;
    bail     = 1'b0;
    while (!saw_done && !bail && edges < 9 * nb + 4) begin
      if (edges == stall_slot) begin
        tx_enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
          rise = (c % 2 == 0);
          fall = (c % 2 == 1);
          @(negedge clk);
        end
        rise = 1'b0;
        fall = 1'b0;
        check({tag, "_stall_sda"}, get_sda(sel), exp_q[0]);
        check({tag, "_stall_state"}, get_state(sel), DATA);
        tx_enable = 1'b1;
      end

      @(negedge clk);
      if (exp_q.size() == 0) begin
        check({tag, "_q_underflow"}, exp_q.size(), 1);
        bail = 1'b1;
      end else begin
        check({tag, "_sda"}, get_sda(sel), exp_q.pop_front());
        check({tag, "_busy"}, get_busy(sel), 1'b1);
        slot_pos  = edges % 9;
        slot_byte = edges / 9;
        if (edges == coin_slot) begin
          if (sel == 1) begin load1 = 1'b1; tx1 = ~data[7:0]; end
          else begin load16 = 1'b1; tx16 = ~data; end
          sda_in = 1'b1;
          rise   = 1'b1;
          fall   = 1'b1;
          @(negedge clk);
          load1  = 1'b0;
          load16 = 1'b0;
          rise   = 1'b0;
          fall   = 1'b0;
          sda_in = 1'b0;
        end else begin
          sda_in = (slot_pos == 8 && slot_byte == nack_byte);
          rise   = 1'b1;
          @(negedge clk);
          rise = 1'b0;
          @(negedge clk);
          if (edges == reset_slot) begin
            check({tag, "_pre_rst_nack"}, get_nack(sel), (slot_pos == 8 && slot_byte == nack_byte));
            #2 n_rst = 1'b0;
            @(negedge clk);
            check({tag, "_rst_sda"}, get_sda(sel), 1'b1);
            check({tag, "_rst_busy"}, get_busy(sel), 1'b0);
            check({tag, "_rst_done"}, get_done(sel), 1'b0);
            check({tag, "_rst_nack"}, get_nack(sel), 1'b0);
            check({tag, "_rst_state"}, get_state(sel), IDLE);
            n_rst  = 1'b1;
            sda_in = 1'b0;
            dn     = 1'b0;
            for (int c = 0; c < 40; c++) begin
              fall = (c % 2 == 1);
              rise = (c % 2 == 0);
              @(negedge clk);
              dn = dn | get_done(sel);
            end
            fall = 1'b0;
            rise = 1'b0;
            check({tag, "_no_done_after_rst"}, dn, 1'b0);
            check({tag, "_idle_after_rst"}, get_state(sel), IDLE);
            exp_q.delete();
            return;
          end
          fall = 1'b1;
          @(negedge clk);
          fall   = 1'b0;
          sda_in = 1'b0;
        end
        edges++;
        saw_done = get_done(sel);
        if (saw_done) check({tag, "_busy_at_done"}, get_busy(sel), 1'b0);
      end
    end

    check({tag, "_done_seen"}, saw_done, 1'b1);
    check({tag, "_edges"}, edges, 9 * sent);
    check({tag, "_nack"}, get_nack(sel), (nack_byte >= 0));
    check({tag, "_q_left"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, get_done(sel), 1'b0);
    check({tag, "_idle_sda"}, get_sda(sel), 1'b1);
    check({tag, "_idle_state"}, get_state(sel), IDLE);
    check({tag, "_nack_hold"}, get_nack(sel), (nack_byte >= 0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [127:0] rnd;
    int           nb_sel;
    load1 = 1'b0; load16 = 1'b0; tx1 = '0; tx16 = '0;
    tx_enable = 1'b1; fall = 1'b0; rise = 1'b0; sda_in = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst1_sda", sda1, 1'b1);
    check("rst1_busy", busy1, 1'b0);
    check("rst1_done", done1, 1'b0);
    check("rst1_nack", nack1, 1'b0);
    check("rst16_sda", sda16, 1'b1);
    check("rst16_busy", busy16, 1'b0);
    check("rst16_done", done16, 1'b0);
    check("rst16_nack", nack16, 1'b0);
    n_rst = 1'b1;
    @(negedge clk);

    run_xfer(1, 128'hA5, -1, -1, -1, -1, "byte_a5");
    run_xfer(16, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, -1, -1, -1, -1, "full128");

    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_xfer(16, rnd, -1, 12, 17, -1, "stall_coin");

    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_xfer(16, rnd, 2, -1, -1, -1, "nack_b2");

    run_xfer(1, 128'h3C, 0, -1, -1, -1, "byte_nack");

    for (int k = 0; k < 3; k++) begin
      rnd    = {96'd0, $urandom};
      nb_sel = ($urandom_range(0, 1) == 1) ? 0 : -1;
      run_xfer(1, rnd, nb_sel, -1, -1, -1, "byte_rand");
    end

    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_xfer(16, rnd, 1, -1, -1, 17, "reset_mid");

    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_xfer(16, rnd, -1, -1, -1, -1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
